instr_decode_stage: RTL and testbench

- Registered decode stage directly upstream of the control unit's select generators, including the ALU B-operand select logic.
- Accepts fetched instruction + PC over a valid/ready handshake.
- Classifies the opcode into the control unit's 10-bit one-hot CODE and flags illegal encodings.
- Presents a registered result through a 2-entry skid buffer, giving full throughput with registered in_ready.

---
 rtl/instr_decode_stage_pkg.sv | 33 +++
 rtl/instr_decode_stage_class_gen.sv | 32 +++
 rtl/instr_decode_stage.sv | 149 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Control-unit shared constants: RV32 major opcodes and one-hot CODE bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package instr_decode_stage_pkg;

  // Width of the one-hot class code consumed by the select generators.
  localparam int CODE_W = 10;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bit positions inside CODE
  localparam int CODE_J     = 0;
  localparam int CODE_JR    = 1;
  localparam int CODE_LUI   = 2;
  localparam int CODE_AUIPC = 3;
  localparam int CODE_BR    = 4;
  localparam int CODE_ALU   = 5;
  localparam int CODE_ST    = 6;
  localparam int CODE_ALUI  = 7;
  localparam int CODE_LD    = 8;
  localparam int CODE_CSR   = 9;

endpackage

// File: rtl/instr_decode_stage_class_gen.sv
// Opcode classifier: instr[6:0] -> one-hot CODE plus illegal flag.
// Latency: purely combinational.
// Backpressure: none (no state).
module instr_class_gen
  import instr_decode_stage_pkg::*;
(
  input  logic [6:0]        opcode,
  output logic [CODE_W-1:0] code,
  output logic              illegal
);

  // Exactly one bit set for a supported opcode; anything else (FENCE,
  // compressed encodings with opcode[1:0]!=11, reserved) is zero + illegal.
  always_comb begin
    code    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_JAL:    code[CODE_J]     = 1'b1;
      OPC_JALR:   code[CODE_JR]    = 1'b1;
      OPC_LUI:    code[CODE_LUI]   = 1'b1;
      OPC_AUIPC:  code[CODE_AUIPC] = 1'b1;
      OPC_BRANCH: code[CODE_BR]    = 1'b1;
      OPC_OP:     code[CODE_ALU]   = 1'b1;
      OPC_STORE:  code[CODE_ST]    = 1'b1;
      OPC_OPIMM:  code[CODE_ALUI]  = 1'b1;
      OPC_LOAD:   code[CODE_LD]    = 1'b1;
      OPC_SYSTEM: code[CODE_CSR]   = 1'b1;
      default:    illegal          = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: classifies instr opcode, holds results in head + skid entries.
// Latency: 1 cycle from accept into an empty stage to out_valid.
// Backpressure: in_ready is registered (~skid_full); skid absorbs the one extra beat.
module instr_decode_stage #(
  parameter int XLEN   = 32,
  parameter int CODE_W = instr_decode_stage_pkg::CODE_W  // fixed at 10 by the control unit
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [CODE_W-1:0] out_code,
  output logic              out_illegal
);

  // Decode happens before storage so both entries hold finished results.
  logic [CODE_W-1:0] dec_code;
  logic              dec_illegal;

  instr_class_gen u_class_gen (
    .opcode  (in_instr[6:0]),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  // State
  logic              head_vld, skid_vld, in_rdy_q;
  logic [31:0]       head_instr, skid_instr;
  logic [XLEN-1:0]   head_pc, skid_pc;
  logic [CODE_W-1:0] head_code, skid_code;
  logic              head_ill, skid_ill;

  // Next state
  logic              head_vld_n, skid_vld_n, in_rdy_n;
  logic [31:0]       head_instr_n, skid_instr_n;
  logic [XLEN-1:0]   head_pc_n, skid_pc_n;
  logic [CODE_W-1:0] head_code_n, skid_code_n;
  logic              head_ill_n, skid_ill_n;

  logic accept, fire;

  assign accept = in_valid & in_rdy_q;
  assign fire   = head_vld & out_ready;

  // Route accepted/forwarded entries between head and skid; flush overrides all.
  always_comb begin
    head_vld_n   = head_vld;
    head_instr_n = head_instr;
    head_pc_n    = head_pc;
    head_code_n  = head_code;
    head_ill_n   = head_ill;
    skid_vld_n   = skid_vld;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    skid_code_n  = skid_code;
    skid_ill_n   = skid_ill;

    if (flush) begin
      head_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (!head_vld) begin
      // Empty stage (skid is never occupied while head is empty).
      if (accept) begin
        head_vld_n   = 1'b1;
        head_instr_n = in_instr;
        head_pc_n    = in_pc;
        head_code_n  = dec_code;
        head_ill_n   = dec_illegal;
      end
    end else if (fire) begin
      if (skid_vld) begin
        // Skid moves up; a new accept cannot happen here since in_ready=0.
        head_instr_n = skid_instr;
        head_pc_n    = skid_pc;
        head_code_n  = skid_code;
        head_ill_n   = skid_ill;
        if (accept) begin
          skid_instr_n = in_instr;
          skid_pc_n    = in_pc;
          skid_code_n  = dec_code;
          skid_ill_n   = dec_illegal;
        end else begin
          skid_vld_n = 1'b0;
        end
      end else if (accept) begin
        // Back-to-back streaming: new entry replaces the departing one.
        head_instr_n = in_instr;
        head_pc_n    = in_pc;
        head_code_n  = dec_code;
        head_ill_n   = dec_illegal;
      end else begin
        head_vld_n = 1'b0;
      end
    end else if (accept) begin
      // Head stalled: park the new entry in the skid.
      skid_vld_n   = 1'b1;
      skid_instr_n = in_instr;
      skid_pc_n    = in_pc;
      skid_code_n  = dec_code;
      skid_ill_n   = dec_illegal;
    end

    in_rdy_n = ~skid_vld_n;
  end

  // State registers; reset discards all entries asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      in_rdy_q   <= 1'b1;
      head_instr <= '0;
      head_pc    <= '0;
      head_code  <= '0;
      head_ill   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_code  <= '0;
      skid_ill   <= 1'b0;
    end else begin
      head_vld   <= head_vld_n;
      skid_vld   <= skid_vld_n;
      in_rdy_q   <= in_rdy_n;
      head_instr <= head_instr_n;
      head_pc    <= head_pc_n;
      head_code  <= head_code_n;
      head_ill   <= head_ill_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      skid_code  <= skid_code_n;
      skid_ill   <= skid_ill_n;
    end
  end

  assign in_ready    = in_rdy_q;
  assign out_valid   = head_vld;
  assign out_instr   = head_instr;
  assign out_pc      = head_pc;
  assign out_code    = head_code;
  assign out_illegal = head_ill;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed scenarios plus randomized traffic vs. a queue model.
// Latency: model expects 1 cycle accept-to-output.
// Backpressure: model treats the stage as a 2-deep FIFO (in_ready = occupancy < 2).
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [9:0]  out_code;
  logic        out_illegal;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .CODE_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_code    (out_code),
    .out_illegal (out_illegal)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the stage is a 2-deep FIFO of (instr, pc).
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_out = 0;

  // Supported opcodes listed in CODE bit order.
  logic [6:0] opc_tbl [10] = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h63,
                               7'h33, 7'h23, 7'h13, 7'h03, 7'h73};

  // Returns {illegal, code[9:0]}.
  function automatic logic [10:0] ref_decode(input logic [31:0] instr);
    for (int i = 0; i < 10; i++)
      if (instr[6:0] == opc_tbl[i]) return {1'b0, 10'(1 << i)};
    return {1'b1, 10'h000};
  endfunction

  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr, prev_pc;
  logic [9:0]  prev_code;
  logic        prev_ill;

  // One clock: drive inputs, check at negedge, update model at posedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, output logic acc);
    logic [10:0] d;
    logic        exp_vld, exp_rdy, fire;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    exp_vld = (q.size() > 0);
    exp_rdy = (q.size() < 2);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (exp_vld) begin
      d = ref_decode(q[0].instr);
      chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
      chk("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
      chk("out_code", {54'd0, out_code}, {54'd0, d[9:0]});
      chk("out_illegal", {63'd0, out_illegal}, {63'd0, d[10]});
    end
    if (prev_stall)
      chk("stall_hold", {out_instr, out_pc ^ {21'd0, prev_code, prev_ill}},
                        {prev_instr, prev_pc ^ {21'd0, out_code, out_illegal}});
    prev_stall = exp_vld & ~ordy & ~fl;
    prev_instr = out_instr;
    prev_pc    = out_pc;
    prev_code  = out_code;
    prev_ill   = out_illegal;
    acc  = v & exp_rdy;
    fire = exp_vld & ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      if (fire) n_out++;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        n_out++;
      end
      if (acc) q.push_back('{instr: ins, pc: pc});
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 7) w[6:0] = opc_tbl[$urandom_range(0, 9)];
    return w;
  endfunction

  logic acc;
  int   base;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_code", {54'd0, out_code}, 64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Decode classes, one at a time with out_ready=1.
    cycle(1, 32'h00500093, 32'h1000, 1, 0, acc);
    chk("addi_code", {54'd0, out_code}, 64'h080);
    chk("addi_ill", {63'd0, out_illegal}, 64'd0);
    chk("addi_vld", {63'd0, out_valid}, 64'd1);
    cycle(1, 32'h0000006F, 32'h1004, 1, 0, acc);
    chk("jal_code", {54'd0, out_code}, 64'h001);
    cycle(1, 32'h00000073, 32'h1008, 1, 0, acc);
    chk("ecall_code", {54'd0, out_code}, 64'h200);
    cycle(1, 32'h0000000F, 32'h100C, 1, 0, acc);
    chk("fence_code", {54'd0, out_code}, 64'h000);
    chk("fence_ill", {63'd0, out_illegal}, 64'd1);
    cycle(1, 32'h00000012, 32'h1010, 1, 0, acc);
    chk("c_ill", {63'd0, out_illegal}, 64'd1);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);

    // Backpressure: A, B, C offered back-to-back with out_ready=0.
    cycle(1, 32'hAAAA0013, 32'h2000, 0, 0, acc);
    cycle(1, 32'hBBBB0033, 32'h2004, 0, 0, acc);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_head_a", {32'd0, out_instr}, 64'hAAAA0013);
    cycle(1, 32'hCCCC0003, 32'h2008, 0, 0, acc);
    chk("bp_c_held", {63'd0, acc}, 64'd0);
    cycle(1, 32'hCCCC0003, 32'h2008, 0, 0, acc);
    base = n_out;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(1, 32'hCCCC0003, 32'h2008, 1, 0, acc);
    chk("bp_c_accepted", {63'd0, acc}, 64'd1);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0, acc);
    chk("bp_out_count", 64'(n_out - base), 64'd3);

    // Full throughput: 8 back-to-back.
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      cycle(1, rand_instr(), 32'h3000 + 32'(i * 4), 1, 0, acc);
      chk("thru_acc", {63'd0, acc}, 64'd1);
    end
    cycle(0, 32'h0, 32'h0, 1, 0, acc);
    chk("thru_count", 64'(n_out - base), 64'd8);

    // Flush with both entries full and an incoming entry.
    cycle(1, 32'h11110013, 32'h4000, 0, 0, acc);
    cycle(1, 32'h22220013, 32'h4004, 0, 0, acc);
    cycle(1, 32'h33330013, 32'h4008, 0, 1, acc);
    chk("flush_vld", {63'd0, out_valid}, 64'd0);
    chk("flush_rdy", {63'd0, in_ready}, 64'd1);
    cycle(0, 32'h0, 32'h0, 1, 0, acc);

    // Asynchronous reset between edges with both entries full.
    cycle(1, 32'h44440013, 32'h5000, 0, 0, acc);
    cycle(1, 32'h55550013, 32'h5004, 0, 0, acc);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_vld", {63'd0, out_valid}, 64'd0);
    chk("arst_code", {54'd0, out_code}, 64'd0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1, 32'h66660037, 32'h6000, 1, 0, acc);
    chk("post_rst_vld", {63'd0, out_valid}, 64'd1);
    chk("post_rst_instr", {32'd0, out_instr}, 64'h66660037);
    chk("post_rst_code", {54'd0, out_code}, 64'h004);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 4) < 3, $urandom_range(0, 49) == 0, acc);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 32'h0, 1, 0, acc);
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
